// File: rtl/pifo_sched_pkg.sv
// Shared types and constants for the PIFO scheduler: FSM encoding, ORDER strings, default widths.
package pifo_sched_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REMOVE = 2'd2
  } state_t;

  localparam string ORDER_MIN      = "MIN";
  localparam string ORDER_MAX      = "MAX";
  localparam int    DEF_RANK_WIDTH = 8;
  localparam int    DEF_META_WIDTH = 8;

  // Strict comparison, so on equal ranks the earlier (lower) index keeps winning.
  function automatic logic rank_better(input logic [31:0] a, input logic [31:0] b,
                                       input logic is_max);
    return is_max ? (a > b) : (a < b);
  endfunction
endpackage

// File: rtl/pifo_sched_if.sv
// Enqueue/dequeue handshake bundle between a client (master) and pifo_sched (slave).
interface pifo_sched_if import pifo_sched_pkg::*; #(
  parameter int L2_NUM_PIFO = 2,
  parameter int RANK_WIDTH  = DEF_RANK_WIDTH,
  parameter int META_WIDTH  = DEF_META_WIDTH
);
  logic                   enq_valid;
  logic                   enq_ready;
  logic [L2_NUM_PIFO-1:0] enq_qid;
  logic [RANK_WIDTH-1:0]  enq_rank;
  logic [META_WIDTH-1:0]  enq_meta;
  logic                   deq_req;
  logic                   deq_ready;
  logic                   deq_valid;
  logic                   deq_empty;
  logic [RANK_WIDTH-1:0]  deq_rank;
  logic [META_WIDTH-1:0]  deq_meta;
  logic [L2_NUM_PIFO-1:0] deq_qid;

  modport master (
    output enq_valid, enq_qid, enq_rank, enq_meta, deq_req,
    input  enq_ready, deq_ready, deq_valid, deq_empty, deq_rank, deq_meta, deq_qid
  );
  modport slave (
    input  enq_valid, enq_qid, enq_rank, enq_meta, deq_req,
    output enq_ready, deq_ready, deq_valid, deq_empty, deq_rank, deq_meta, deq_qid
  );
endinterface

// File: rtl/pifo_head_sel.sv
// Combinational NUM_PIFO-way best-head select; ties resolve to the lowest index.
module pifo_head_sel import pifo_sched_pkg::*; #(
  parameter int    NUM_PIFO    = 4,
  parameter int    L2_NUM_PIFO = 2,
  parameter int    RANK_WIDTH  = DEF_RANK_WIDTH,
  parameter string ORDER       = ORDER_MIN
) (
  input  logic [NUM_PIFO-1:0][RANK_WIDTH-1:0] i_heads,
  input  logic [NUM_PIFO-1:0]                 i_mask,
  output logic [L2_NUM_PIFO-1:0]              o_idx,
  output logic                                o_any
);
  localparam bit IS_MAX = (ORDER == ORDER_MAX);

  logic [RANK_WIDTH-1:0] w_best;

  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_best = '0;
    for (int q = 0; q < NUM_PIFO; q++)
      if (i_mask[q] && (!o_any || rank_better(32'(i_heads[q]), 32'(w_best), IS_MAX))) begin
        o_idx  = L2_NUM_PIFO'(q);
        o_any  = 1'b1;
        w_best = i_heads[q];
      end
  end
endmodule

// File: rtl/pifo_sched.sv
// Enqueue steering, best-head dequeue FSM and per-PIFO occupancy/settle tracking for a bank of pifo_reg.
module pifo_sched import pifo_sched_pkg::*; #(
  parameter int    NUM_PIFO    = 4,
  parameter int    L2_NUM_PIFO = 2,
  parameter int    L2_MAX_SIZE = 3,
  parameter int    RANK_WIDTH  = DEF_RANK_WIDTH,
  parameter int    META_WIDTH  = DEF_META_WIDTH,
  parameter string ORDER       = ORDER_MIN,
  parameter int    SETTLE      = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  pifo_sched_if.slave                         bus,
  output logic [NUM_PIFO-1:0]                 o_pifo_insert,
  output logic [NUM_PIFO-1:0]                 o_pifo_remove,
  output logic [RANK_WIDTH-1:0]               o_pifo_rank_in,
  output logic [META_WIDTH-1:0]               o_pifo_meta_in,
  input  logic [NUM_PIFO*RANK_WIDTH-1:0]      i_pifo_rank_out,
  input  logic [NUM_PIFO*META_WIDTH-1:0]      i_pifo_meta_out,
  input  logic [NUM_PIFO-1:0]                 i_pifo_valid_out,
  output logic [NUM_PIFO*(L2_MAX_SIZE+1)-1:0] o_q_count
);
  localparam int            CW  = L2_MAX_SIZE + 1;
  localparam int            BW  = $clog2(SETTLE + 2);
  localparam logic [CW-1:0] CAP = CW'((1 << L2_MAX_SIZE) - 1);

  state_t                              r_state, w_next;
  logic [NUM_PIFO-1:0][CW-1:0]         r_count;
  logic [NUM_PIFO-1:0][BW-1:0]         r_busy;
  logic [NUM_PIFO-1:0][RANK_WIDTH-1:0] w_heads;
  logic [NUM_PIFO-1:0][META_WIDTH-1:0] w_metas;
  logic [NUM_PIFO-1:0]                 w_nz, w_bz, w_mask, w_ins, w_rem;
  logic [L2_NUM_PIFO-1:0]              w_idx;
  logic                                w_any, w_hold;
  logic                                w_enq_ready, w_deq_ready, w_enq_acc, w_deq_acc;
  logic                                w_sel, w_empty;
  logic                                r_deq_valid, r_deq_empty;
  logic [RANK_WIDTH-1:0]               r_deq_rank;
  logic [META_WIDTH-1:0]               r_deq_meta;
  logic [L2_NUM_PIFO-1:0]              r_deq_qid;

  assign w_heads = i_pifo_rank_out;
  assign w_metas = i_pifo_meta_out;

  always_comb begin
    for (int q = 0; q < NUM_PIFO; q++) begin
      w_nz[q] = (r_count[q] != '0);
      w_bz[q] = (r_busy[q] != '0);
    end
  end

  // A non-empty PIFO still settling makes its head untrustworthy; empty ones never block.
  assign w_hold = |(w_nz & w_bz);
  assign w_mask = w_nz & i_pifo_valid_out;

  pifo_head_sel #(
    .NUM_PIFO(NUM_PIFO), .L2_NUM_PIFO(L2_NUM_PIFO), .RANK_WIDTH(RANK_WIDTH), .ORDER(ORDER)
  ) u_sel (
    .i_heads(w_heads), .i_mask(w_mask), .o_idx(w_idx), .o_any(w_any)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_deq_acc) w_next = ST_WAIT;
      ST_WAIT:  if (!w_hold)   w_next = w_any ? ST_REMOVE : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Readies are gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    w_deq_ready = rst_n && (r_state == ST_IDLE);
    w_enq_ready = w_deq_ready && (r_count[bus.enq_qid] < CAP) && !w_bz[bus.enq_qid];
    w_enq_acc   = bus.enq_valid && w_enq_ready;
    w_deq_acc   = bus.deq_req && w_deq_ready;
    w_sel       = (r_state == ST_WAIT) && !w_hold && w_any;
    w_empty     = (r_state == ST_WAIT) && !w_hold && !w_any;
    w_ins       = NUM_PIFO'(w_enq_acc) << bus.enq_qid;
    w_rem       = NUM_PIFO'(w_sel) << w_idx;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_count <= '0;
      r_busy  <= '0;
    end else begin
      for (int q = 0; q < NUM_PIFO; q++) begin
        if (w_ins[q] || w_rem[q]) r_busy[q] <= BW'(SETTLE + 1);
        else if (w_bz[q])         r_busy[q] <= r_busy[q] - BW'(1);
        if (w_ins[q])             r_count[q] <= r_count[q] + CW'(1);
        else if (w_rem[q])        r_count[q] <= r_count[q] - CW'(1);
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_pifo_insert  <= '0;
      o_pifo_remove  <= '0;
      o_pifo_rank_in <= '0;
      o_pifo_meta_in <= '0;
      r_deq_valid    <= 1'b0;
      r_deq_empty    <= 1'b0;
      r_deq_rank     <= '0;
      r_deq_meta     <= '0;
      r_deq_qid      <= '0;
    end else begin
      o_pifo_insert <= w_ins;
      o_pifo_remove <= w_rem;
      r_deq_valid   <= w_sel;
      r_deq_empty   <= w_empty;
      if (w_enq_acc) begin
        o_pifo_rank_in <= bus.enq_rank;
        o_pifo_meta_in <= bus.enq_meta;
      end
      if (w_sel) begin
        r_deq_rank <= w_heads[w_idx];
        r_deq_meta <= w_metas[w_idx];
        r_deq_qid  <= w_idx;
      end
    end

  assign bus.enq_ready = w_enq_ready;
  assign bus.deq_ready = w_deq_ready;
  assign bus.deq_valid = r_deq_valid;
  assign bus.deq_empty = r_deq_empty;
  assign bus.deq_rank  = r_deq_rank;
  assign bus.deq_meta  = r_deq_meta;
  assign bus.deq_qid   = r_deq_qid;
  assign o_q_count     = r_count;
endmodule

// File: tb/tb_pifo_sched.sv
// Bench for pifo_sched: behavioural PIFO bank, global ordered-set reference, directed table and random mix.
module tb_pifo_sched;
  import pifo_sched_pkg::*;
  localparam int NP = 4, LQ = 2, LS = 3, RW = 8, MW = 8, CW = LS + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pifo_sched_if #(.L2_NUM_PIFO(LQ), .RANK_WIDTH(RW), .META_WIDTH(MW)) bus();

  logic [NP-1:0]         ins, rem, hv;
  logic [RW-1:0]         rin;
  logic [MW-1:0]         mdin;
  logic [NP-1:0][RW-1:0] hr;
  logic [NP-1:0][MW-1:0] hm;
  logic [NP*CW-1:0]      qc;

  pifo_sched #(.NUM_PIFO(NP), .L2_NUM_PIFO(LQ), .L2_MAX_SIZE(LS), .RANK_WIDTH(RW),
               .META_WIDTH(MW), .ORDER("MIN"), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .o_pifo_insert(ins), .o_pifo_remove(rem), .o_pifo_rank_in(rin), .o_pifo_meta_in(mdin),
    .i_pifo_rank_out(hr), .i_pifo_meta_out(hm), .i_pifo_valid_out(hv), .o_q_count(qc)
  );

  int checks = 0, errors = 0, ins0_cnt = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Behavioural PIFO bank: heads lag the stored set by one register stage.
  logic [15:0] pq [NP][$];
  function automatic int best_idx(int q);
    int b = -1;
    for (int i = 0; i < pq[q].size(); i++)
      if (b < 0 || pq[q][i][15:8] < pq[q][b][15:8]) b = i;
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin : pifo_bank
    int b;
    if (!rst_n) begin
      for (int q = 0; q < NP; q++) pq[q].delete();
      hv <= '0; hr <= '0; hm <= '0;
    end else begin
      for (int q = 0; q < NP; q++) begin
        b = best_idx(q);
        hv[q] <= (b >= 0);
        if (b >= 0) begin hr[q] <= pq[q][b][15:8]; hm[q] <= pq[q][b][7:0]; end
        if (ins[q]) pq[q].push_back({rin, mdin});
        if (rem[q]) begin b = best_idx(q); if (b >= 0) pq[q].delete(b); end
      end
    end
  end

  // Reference: one global set; dequeue = min rank, then lowest qid, then oldest.
  typedef struct {int rank; int meta; int qid; int seq;} el_t;
  typedef struct {bit empty; int rank; int meta; int qid;} res_t;
  el_t  ref_q[$];
  res_t exp_q[$];
  int   ref_cnt[NP];
  int   seq = 0;

  function automatic res_t ref_pop();
    res_t r;
    int b = -1;
    r.empty = 1'b1; r.rank = 0; r.meta = 0; r.qid = 0;
    foreach (ref_q[i])
      if (b < 0 || ref_q[i].rank < ref_q[b].rank ||
          (ref_q[i].rank == ref_q[b].rank && (ref_q[i].qid < ref_q[b].qid ||
           (ref_q[i].qid == ref_q[b].qid && ref_q[i].seq < ref_q[b].seq)))) b = i;
    if (b >= 0) begin
      r.empty = 1'b0; r.rank = ref_q[b].rank; r.meta = ref_q[b].meta; r.qid = ref_q[b].qid;
      ref_cnt[ref_q[b].qid]--;
      ref_q.delete(b);
    end
    return r;
  endfunction

  always @(negedge clk) begin : monitor
    res_t e;
    if (rst_n) begin
      chk("ins_rem_overlap", int'(ins & rem), 0);
      if (ins[0]) ins0_cnt++;
      if (bus.deq_valid || bus.deq_empty) begin
        chk("deq_valid_and_empty", int'(bus.deq_valid && bus.deq_empty), 0);
        if (exp_q.size() == 0) chk("unexpected_deq_pulse", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("deq_empty_vs_model", int'(bus.deq_empty), int'(e.empty));
          if (!e.empty) begin
            chk("deq_rank_vs_model", int'(bus.deq_rank), e.rank);
            chk("deq_qid_vs_model", int'(bus.deq_qid), e.qid);
            chk("deq_meta_vs_model", int'(bus.deq_meta), e.meta);
          end
        end
      end
    end
  end

  task automatic step(input bit ev, input int qid, input int rank, input int meta, input bit dq,
                      output bit ae, output bit ad);
    @(negedge clk);
    bus.enq_valid = ev; bus.enq_qid = qid[LQ-1:0]; bus.enq_rank = rank[RW-1:0];
    bus.enq_meta = meta[MW-1:0]; bus.deq_req = dq;
    #1;
    ae = ev && bus.enq_ready;
    ad = dq && bus.deq_ready;
    @(posedge clk);
    if (ae) begin
      ref_q.push_back('{rank: rank, meta: meta, qid: qid, seq: seq});
      seq++; ref_cnt[qid]++;
    end
    if (ad) exp_q.push_back(ref_pop());
    #1;
    bus.enq_valid = 1'b0; bus.deq_req = 1'b0;
  endtask

  task automatic idle(input int n);
    bit ae, ad;
    repeat (n) step(0, 0, 0, 0, 0, ae, ad);
  endtask

  task automatic enq(input int qid, input int rank, input int meta);
    bit ae, ad;
    ae = 1'b0;
    for (int i = 0; i < 20 && !ae; i++) step(1, qid, rank, meta, 0, ae, ad);
    if (!ae) chk("enq_accept_timeout", 0, 1);
  endtask

  task automatic wait_res(output res_t got, output int lat);
    got.empty = 1'b1; got.rank = -1; got.meta = -1; got.qid = -1; lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (bus.deq_valid || bus.deq_empty) begin
        got.empty = bus.deq_empty; got.rank = int'(bus.deq_rank);
        got.meta = int'(bus.deq_meta); got.qid = int'(bus.deq_qid);
        return;
      end
    end
    chk("deq_result_timeout", 0, 1);
  endtask

  task automatic deq(output res_t got, output int lat);
    bit ae, ad;
    ad = 1'b0;
    for (int i = 0; i < 30 && !ad; i++) step(0, 0, 0, 0, 1, ae, ad);
    if (!ad) begin
      chk("deq_accept_timeout", 0, 1);
      got.empty = 1'b0; got.rank = -1; got.meta = -1; got.qid = -1; lat = 0;
    end else wait_res(got, lat);
  endtask

  task automatic drain();
    res_t g;
    int l;
    for (int i = 0; i < 40; i++) begin
      deq(g, l);
      if (g.empty) return;
    end
    chk("drain_timeout", 0, 1);
  endtask

  task automatic check_rdy(input string name, input int qid, input int want);
    bus.enq_qid = qid[LQ-1:0];
    #1;
    chk(name, int'(bus.enq_ready), want);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_enq_ready"}, int'(bus.enq_ready), 0);
    chk({tag, "_deq_ready"}, int'(bus.deq_ready), 0);
    chk({tag, "_deq_valid"}, int'(bus.deq_valid), 0);
    chk({tag, "_deq_empty"}, int'(bus.deq_empty), 0);
    chk({tag, "_deq_rank"}, int'(bus.deq_rank), 0);
    chk({tag, "_strobes"}, int'({ins, rem}), 0);
    chk({tag, "_pifo_in"}, int'({rin, mdin}), 0);
    chk({tag, "_q_count"}, int'(qc), 0);
  endtask

  typedef struct {bit en; int qid; int rank; bit ex_empty; int ex_rank; int ex_qid;} vec_t;
  vec_t vt[$];

  initial begin
    res_t g;
    int   lat;
    bit   ae, ad;
    bus.enq_valid = 1'b0; bus.enq_qid = '0; bus.enq_rank = '0; bus.enq_meta = '0; bus.deq_req = 1'b0;
    for (int q = 0; q < NP; q++) ref_cnt[q] = 0;

    #12 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Reset while a dequeue sits in WAIT.
    enq(0, 20, 1);
    step(0, 0, 0, 0, 1, ae, ad);
    chk("rst_deq_accepted", int'(ad), 1);
    rst_n = 1'b0;
    #1 check_all_zero("midreset");
    ref_q.delete(); exp_q.delete();
    for (int q = 0; q < NP; q++) ref_cnt[q] = 0;
    #14 @(negedge clk) rst_n = 1'b1;
    deq(g, lat);
    chk("after_reset_empty", int'(g.empty), 1);

    // Three enqueues into q0, min comes out first with the idle latency.
    ins0_cnt = 0;
    enq(0, 5, 50); enq(0, 2, 20); enq(0, 9, 90);
    idle(5);
    chk("ins0_pulses", ins0_cnt, 3);
    chk("q0_count_3", int'(qc[0 +: CW]), 3);
    deq(g, lat);
    chk("q0_deq_rank", g.rank, 2);
    chk("q0_deq_qid", g.qid, 0);
    chk("q0_deq_meta", g.meta, 20);
    chk("idle_deq_latency", lat, 2);
    drain();

    // Table: cross-queue ordering and lowest-qid tie-break.
    vt.push_back('{1, 0, 7, 0, 0, 0});
    vt.push_back('{1, 1, 3, 0, 0, 0});
    vt.push_back('{1, 2, 3, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 3, 1});
    vt.push_back('{0, 0, 0, 0, 3, 2});
    vt.push_back('{0, 0, 0, 0, 7, 0});
    vt.push_back('{0, 0, 0, 1, 0, 0});
    vt.push_back('{1, 3, 1, 0, 0, 0});
    vt.push_back('{1, 2, 1, 0, 0, 0});
    vt.push_back('{1, 0, 255, 0, 0, 0});
    vt.push_back('{1, 1, 0, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 0, 1});
    vt.push_back('{0, 0, 0, 0, 1, 2});
    vt.push_back('{0, 0, 0, 0, 1, 3});
    vt.push_back('{0, 0, 0, 0, 255, 0});
    vt.push_back('{0, 0, 0, 1, 0, 0});
    foreach (vt[i]) begin
      if (vt[i].en) enq(vt[i].qid, vt[i].rank, vt[i].rank ^ 8'hA5);
      else begin
        deq(g, lat);
        chk($sformatf("vec%0d_empty", i), int'(g.empty), int'(vt[i].ex_empty));
        if (!vt[i].ex_empty) begin
          chk($sformatf("vec%0d_rank", i), g.rank, vt[i].ex_rank);
          chk($sformatf("vec%0d_qid", i), g.qid, vt[i].ex_qid);
        end
      end
    end

    // Fill q3 to capacity.
    for (int i = 0; i < 7; i++) enq(3, 10 + i, i);
    idle(5);
    chk("q3_count_full", int'(qc[3*CW +: CW]), 7);
    check_rdy("q3_full_not_ready", 3, 0);
    check_rdy("q0_ready_while_q3_full", 0, 1);
    deq(g, lat);
    chk("q3_deq_rank", g.rank, 10);
    chk("q3_deq_qid", g.qid, 3);
    idle(1);
    check_rdy("q3_busy_after_remove", 3, 0);
    idle(5);
    check_rdy("q3_ready_after_settle", 3, 1);
    drain();

    // Same-cycle enqueue and dequeue: WAIT holds until q1 settles.
    enq(1, 4, 44);
    idle(5);
    step(1, 1, 0, 8'h55, 1, ae, ad);
    chk("same_cycle_enq_acc", int'(ae), 1);
    chk("same_cycle_deq_acc", int'(ad), 1);
    wait_res(g, lat);
    chk("same_cycle_rank", g.rank, 0);
    chk("same_cycle_qid", g.qid, 1);
    chk("same_cycle_hold", int'(lat > 2), 1);
    drain();

    // Random mix against the reference.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, NP - 1), $urandom_range(0, 15),
           $urandom_range(0, 255), $urandom_range(0, 3) == 0, ae, ad);
    idle(30);
    chk("random_pending_results", exp_q.size(), 0);
    for (int q = 0; q < NP; q++)
      chk($sformatf("random_q%0d_count", q), int'(qc[q*CW +: CW]), ref_cnt[q]);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
